seg7_scan_decoder: RTL and testbench

- Reverse path of the team's BCD-to-7-segment decoder: observes a multiplexed 7-segment bus and recovers BCD digits.
- Samples segment lines g..a per digit-enable strobe. Requires STABLE_CNT consecutive identical samples before committing a digit. Flags illegal patterns.
- Presents a full frame of digits through a valid/ready output register.
- Used in display-loopback self-test and in the front-panel capture path.

---
 rtl/seg7_pkg.sv | 27 ++
 rtl/seg7_scan_decoder_if.sv | 20 ++
 rtl/seg7_pattern_decode.sv | 29 ++
 rtl/seg7_scan_decoder.sv | 145 ++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment scan decoder.
package seg7_pkg;

    localparam logic [6:0] SEG7_P0    = 7'h3F;
    localparam logic [6:0] SEG7_P1    = 7'h06;
    localparam logic [6:0] SEG7_P2    = 7'h5B;
    localparam logic [6:0] SEG7_P3    = 7'h4F;
    localparam logic [6:0] SEG7_P4    = 7'h66;
    localparam logic [6:0] SEG7_P5    = 7'h6D;
    localparam logic [6:0] SEG7_P6    = 7'h7D;
    localparam logic [6:0] SEG7_P7    = 7'h07;
    localparam logic [6:0] SEG7_P8    = 7'h7F;
    localparam logic [6:0] SEG7_P9    = 7'h6F;
    localparam logic [6:0] SEG7_BLANK = 7'h00;

    localparam logic [3:0] BCD_BLANK   = 4'hF;
    localparam logic [3:0] BCD_ILLEGAL = 4'hE;

    // Wide enough for the largest stability threshold (15).
    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } out_state_e;

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// Frame output channel: committed BCD frame with valid/ready handshake.
interface seg7_scan_decoder_if #(
    parameter int unsigned NDIG = 4
) ();
    logic [4*NDIG-1:0] bcd;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output bcd,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  bcd,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment pattern to BCD code; unknown patterns flagged illegal.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pat_i,
    output logic [3:0] code_c_o,
    output logic       illegal_c_o
);

    always_comb begin
        code_c_o    = BCD_ILLEGAL;
        illegal_c_o = 1'b0;
        case (pat_i)
            SEG7_P0:    code_c_o = 4'd0;
            SEG7_P1:    code_c_o = 4'd1;
            SEG7_P2:    code_c_o = 4'd2;
            SEG7_P3:    code_c_o = 4'd3;
            SEG7_P4:    code_c_o = 4'd4;
            SEG7_P5:    code_c_o = 4'd5;
            SEG7_P6:    code_c_o = 4'd6;
            SEG7_P7:    code_c_o = 4'd7;
            SEG7_P8:    code_c_o = 4'd8;
            SEG7_P9:    code_c_o = 4'd9;
            SEG7_BLANK: code_c_o = BCD_BLANK;
            default:    illegal_c_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers BCD digits from a multiplexed 7-segment bus and presents whole frames.
// Define SEG7_ACTIVE_LOW_EN for common-anode (active-low) segment lines.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned NDIG       = 4,
    parameter int unsigned STABLE_CNT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           seg,
    input  logic [NDIG-1:0]      dig_en,
    input  logic                 sample_en,
    seg7_scan_decoder_if.master  frame,
    output logic [NDIG-1:0]      digit_err,
    output logic                 onehot_err,
    output logic                 overrun
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT);

    logic [6:0]                 seg_in_c;
    logic [3:0]                 code_c;
    logic                       illegal_c;
    logic                       is_onehot_c;
    logic                       accept_c;
    logic                       frame_load_c;
    logic [CNT_W-1:0]           cnt_nx_c;

    logic [NDIG-1:0][3:0]       cand_q, cand_d;
    logic [NDIG-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [4*NDIG-1:0]          committed_q, committed_d;
    logic [NDIG-1:0]            digit_err_q, digit_err_d;
    logic [NDIG-1:0]            mask_q, mask_d;
    logic                       onehot_err_q, onehot_err_d;
    logic [4*NDIG-1:0]          bcd_q, bcd_d;
    logic                       out_valid_q, out_valid_d;
    logic                       overrun_q, overrun_d;
    out_state_e                 state_q, state_d;

    // Polarity is normalised here so all pattern constants stay active-high.
`ifdef SEG7_ACTIVE_LOW_EN
    assign seg_in_c = ~seg;
`else
    assign seg_in_c = seg;
`endif

    assign is_onehot_c  = (dig_en != '0) && ((dig_en & (dig_en - NDIG'(1))) == '0);
    assign accept_c     = sample_en && is_onehot_c;
    assign frame_load_c = &mask_q;

    seg7_pattern_decode u_decode (
        .pat_i       (seg_in_c),
        .code_c_o    (code_c),
        .illegal_c_o (illegal_c)
    );

    // Per-digit debounce: candidate/count update, commit of stable legal codes.
    always_comb begin
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        committed_d = committed_q;
        digit_err_d = digit_err_q;
        cnt_nx_c    = '0;
        for (int unsigned k = 0; k < NDIG; k++) begin
            if (accept_c && dig_en[k]) begin
                if (code_c == cand_q[k]) begin
                    cnt_nx_c = (cnt_q[k] >= CNT_MAX) ? CNT_MAX : cnt_q[k] + CNT_W'(1);
                end else begin
                    cand_d[k] = code_c;
                    cnt_nx_c  = CNT_W'(1);
                end
                cnt_d[k] = cnt_nx_c;
                if ((cnt_nx_c == CNT_MAX) && !illegal_c) begin
                    committed_d[4*k +: 4] = code_c;
                end
                digit_err_d[k] = illegal_c;
            end
        end
    end

    // A full mask is consumed by the load on the following edge.
    always_comb begin
        mask_d       = (frame_load_c ? '0 : mask_q) | (accept_c ? dig_en : '0);
        onehot_err_d = onehot_err_q | (sample_en & ~is_onehot_c);
    end

    // Output FSM next state: a frame load always wins over a handshake.
    always_comb begin
        state_d   = state_q;
        bcd_d     = bcd_q;
        overrun_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_load_c) begin
                    state_d = VALID;
                    bcd_d   = committed_q;
                end
            end
            VALID: begin
                if (frame_load_c) begin
                    bcd_d     = committed_q;
                    overrun_d = ~frame.out_ready;
                end else if (frame.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        out_valid_d = (state_d == VALID);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cand_q       <= '0;
            cnt_q        <= '0;
            committed_q  <= '0;
            digit_err_q  <= '0;
            mask_q       <= '0;
            onehot_err_q <= 1'b0;
            bcd_q        <= '0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
            state_q      <= IDLE;
        end else begin
            cand_q       <= cand_d;
            cnt_q        <= cnt_d;
            committed_q  <= committed_d;
            digit_err_q  <= digit_err_d;
            mask_q       <= mask_d;
            onehot_err_q <= onehot_err_d;
            bcd_q        <= bcd_d;
            out_valid_q  <= out_valid_d;
            overrun_q    <= overrun_d;
            state_q      <= state_d;
        end
    end

    assign frame.bcd       = bcd_q;
    assign frame.out_valid = out_valid_q;
    assign digit_err       = digit_err_q;
    assign onehot_err      = onehot_err_q;
    assign overrun         = overrun_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder (NDIG=4, STABLE_CNT=2); inverts stimulus under SEG7_ACTIVE_LOW_EN.
module tb_seg7_scan_decoder;

    localparam int unsigned NDIG = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [6:0]      seg;
    logic [NDIG-1:0] dig_en;
    logic            sample_en;
    logic [NDIG-1:0] digit_err;
    logic            onehot_err;
    logic            overrun;

    int checks   = 0;
    int failures = 0;

    seg7_scan_decoder_if #(.NDIG(NDIG)) frame_if ();

    seg7_scan_decoder #(.NDIG(NDIG), .STABLE_CNT(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg        (seg),
        .dig_en     (dig_en),
        .sample_en  (sample_en),
        .frame      (frame_if),
        .digit_err  (digit_err),
        .onehot_err (onehot_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] pin(input logic [6:0] p);
`ifdef SEG7_ACTIVE_LOW_EN
        return ~p;
`else
        return p;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp(input int d, input logic [6:0] p);
        dig_en    = NDIG'(1 << d);
        seg       = pin(p);
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        dig_en    = '0;
    endtask

    // Digits scanned 3 down to 0, one accepted sample each.
    task automatic scan(input logic [6:0] p3, input logic [6:0] p2,
                        input logic [6:0] p1, input logic [6:0] p0);
        smp(3, p3);
        smp(2, p2);
        smp(1, p1);
        smp(0, p0);
    endtask

    // One frame with out_ready=1: load on the next edge, drop on the one after.
    task automatic frame_ack(input string tag, input logic [6:0] p3, input logic [6:0] p2,
                             input logic [6:0] p1, input logic [6:0] p0,
                             input logic [15:0] exp_bcd, input logic [3:0] exp_err);
        scan(p3, p2, p1, p0);
        check({tag, "_pre_valid"}, frame_if.out_valid, 0);
        tick();
        check({tag, "_valid"}, frame_if.out_valid, 1);
        check({tag, "_bcd"}, frame_if.bcd, exp_bcd);
        check({tag, "_err"}, digit_err, exp_err);
        tick();
        check({tag, "_drop"}, frame_if.out_valid, 0);
    endtask

    initial begin
        rst = 1'b1;
        seg = '0;
        dig_en = '0;
        sample_en = 1'b0;
        frame_if.out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_bcd", frame_if.bcd, 0);
        check("rst_valid", frame_if.out_valid, 0);
        check("rst_err", digit_err, 0);
        check("rst_onehot", onehot_err, 0);
        check("rst_overrun", overrun, 0);

        // First frame loads nothing committed yet; second commits 3210.
        frame_ack("fa", 7'h4F, 7'h5B, 7'h06, 7'h3F, 16'h0000, 4'h0);
        frame_ack("fb", 7'h4F, 7'h5B, 7'h06, 7'h3F, 16'h3210, 4'h0);

        // Digit 1 alternates 1/7: never stable, keeps committed 1.
        frame_ack("fc", 7'h4F, 7'h5B, 7'h07, 7'h3F, 16'h3210, 4'h0);
        frame_ack("fd", 7'h4F, 7'h5B, 7'h06, 7'h3F, 16'h3210, 4'h0);
        frame_ack("fe", 7'h4F, 7'h5B, 7'h07, 7'h3F, 16'h3210, 4'h0);

        // Illegal pattern on digit 2, stable but never committed; then legal 6.
        frame_ack("ff1", 7'h4F, 7'h55, 7'h06, 7'h3F, 16'h3210, 4'h4);
        frame_ack("ff2", 7'h4F, 7'h55, 7'h06, 7'h3F, 16'h3210, 4'h4);
        frame_ack("fg", 7'h4F, 7'h7D, 7'h06, 7'h3F, 16'h3210, 4'h0);
        frame_ack("fh", 7'h4F, 7'h7D, 7'h06, 7'h3F, 16'h3610, 4'h0);

        // Overrun: two frames with no consumer.
        frame_if.out_ready = 1'b0;
        scan(7'h4F, 7'h6D, 7'h06, 7'h3F);
        tick();
        check("fi_valid", frame_if.out_valid, 1);
        check("fi_bcd", frame_if.bcd, 16'h3610);
        check("fi_overrun", overrun, 0);
        scan(7'h4F, 7'h6D, 7'h06, 7'h3F);
        check("fj_hold_bcd", frame_if.bcd, 16'h3610);
        tick();
        check("fj_overrun", overrun, 1);
        check("fj_bcd", frame_if.bcd, 16'h3510);
        check("fj_valid", frame_if.out_valid, 1);
        tick();
        check("fj_overrun_pulse", overrun, 0);
        check("fj_still_valid", frame_if.out_valid, 1);
        frame_if.out_ready = 1'b1;
        tick();
        check("fj_drop", frame_if.out_valid, 0);

        // Multi-hot strobe: flagged, and neither counts nor marks the mask.
        smp(0, 7'h7F);
        dig_en    = 4'b0011;
        seg       = pin(7'h7F);
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        dig_en    = '0;
        check("oh_err", onehot_err, 1);
        smp(3, 7'h4F);
        smp(2, 7'h6D);
        smp(1, 7'h06);
        check("oh_no_early_load", frame_if.out_valid, 0);
        tick();
        check("oh_valid", frame_if.out_valid, 1);
        check("oh_bcd", frame_if.bcd, 16'h3510);
        tick();
        check("oh_sticky", onehot_err, 1);

        // Reset mid-frame clears everything including partial mask/candidates.
        smp(0, 7'h3F);
        smp(3, 7'h4F);
        smp(2, 7'h5B);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_bcd", frame_if.bcd, 0);
        check("mr_valid", frame_if.out_valid, 0);
        check("mr_onehot", onehot_err, 0);
        check("mr_err", digit_err, 0);
        smp(3, 7'h4F);
        smp(2, 7'h5B);
        smp(1, 7'h06);
        tick();
        tick();
        check("mr_partial", frame_if.out_valid, 0);
        smp(0, 7'h3F);
        tick();
        check("mr_valid1", frame_if.out_valid, 1);
        check("mr_bcd1", frame_if.bcd, 16'h0000);
        tick();
        frame_ack("mr2", 7'h4F, 7'h5B, 7'h06, 7'h3F, 16'h3210, 4'h0);

        // Blank digit decodes to F.
        frame_ack("bl1", 7'h00, 7'h5B, 7'h06, 7'h3F, 16'h3210, 4'h0);
        frame_ack("bl2", 7'h00, 7'h5B, 7'h06, 7'h3F, 16'hF210, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
